// File: rtl/truth_table_capture_if.sv
// Sample handshake between a truth-table stimulus driver and its capture block.
//   in_valid : driver has a sample on in_vec/in_y
//   in_ready : capture block can take a sample this cycle
//   in_vec   : input combination (bit N_IN-1 = a ... bit 0 = c)
//   in_y     : function output observed for in_vec
interface truth_table_capture_if #(
  parameter int N_IN = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_y;

  modport master (
    output in_valid,
    output in_vec,
    output in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  in_y,
    output in_ready
  );
endinterface

// File: rtl/truth_table_capture.sv
// Builds the truth table of an N_IN-input function from (vector, y) samples,
// flags conflicting duplicates and, once every entry has been seen, compares
// the captured table against expect_tt.
//   clk, reset    : clock and asynchronous active-high reset
//   clear         : synchronous restart, wins over a same-cycle accept
//   smp           : sample handshake (slave side)
//   expect_tt     : expected table, bit i = y for in_vec == i
//   table_out     : captured y per index
//   seen_out      : 1 = index captured
//   count         : number of distinct indices captured
//   done / pass   : all indices captured / table matched at completion
//   conflict      : duplicate index arrived with a different y
//   conflict_idx  : index of that first conflict
//
// state   | meaning
// --------+---------------------------------------------------------
// COLLECT | accepting samples, table partially filled
// DONE    | every index captured, pass frozen, samples refused
// ERROR   | conflicting duplicate seen, table frozen, samples refused
module truth_table_capture #(
  parameter int N_IN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  truth_table_capture_if.slave  smp,
  input  logic [2**N_IN-1:0]    expect_tt,
  output logic [2**N_IN-1:0]    table_out,
  output logic [2**N_IN-1:0]    seen_out,
  output logic [N_IN:0]         count,
  output logic                  done,
  output logic                  pass,
  output logic                  conflict,
  output logic [N_IN-1:0]       conflict_idx
);

  localparam int DEPTH = 2**N_IN;
  localparam logic [N_IN:0] FULL = (N_IN+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DONE    = 2'd1,
    S_ERROR   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  table_q, table_d;
  logic [DEPTH-1:0]  seen_q, seen_d;
  logic [N_IN:0]     count_q, count_d;
  logic              pass_q, pass_d;
  logic              conflict_q, conflict_d;
  logic [N_IN-1:0]   cidx_q, cidx_d;
  logic              accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      table_q    <= '0;
      seen_q     <= '0;
      count_q    <= '0;
      pass_q     <= 1'b0;
      conflict_q <= 1'b0;
      cidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      seen_q     <= seen_d;
      count_q    <= count_d;
      pass_q     <= pass_d;
      conflict_q <= conflict_d;
      cidx_q     <= cidx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    seen_d     = seen_q;
    count_d    = count_q;
    pass_d     = pass_q;
    conflict_d = conflict_q;
    cidx_d     = cidx_q;
    accept     = smp.in_valid && (state_q == S_COLLECT);

    if (clear) begin
      state_d    = S_COLLECT;
      table_d    = '0;
      seen_d     = '0;
      count_d    = '0;
      pass_d     = 1'b0;
      conflict_d = 1'b0;
      cidx_d     = '0;
    end else if (accept) begin
      if (!seen_q[smp.in_vec]) begin
        table_d[smp.in_vec] = smp.in_y;
        seen_d[smp.in_vec]  = 1'b1;
        if (count_q != FULL) begin
          count_d = count_q + 1'b1;
        end
        // Completing sample: compare the table including this new entry.
        if (count_q == FULL - 1'b1) begin
          state_d = S_DONE;
          pass_d  = (table_d == expect_tt);
        end
      end else if (table_q[smp.in_vec] != smp.in_y) begin
        state_d    = S_ERROR;
        conflict_d = 1'b1;
        cidx_d     = smp.in_vec;
      end
    end
  end

  // Ready comes from the registered state only, never from in_valid.
  assign smp.in_ready = (state_q == S_COLLECT);

  assign table_out    = table_q;
  assign seen_out     = seen_q;
  assign count        = count_q;
  assign done         = (state_q == S_DONE);
  assign pass         = pass_q;
  assign conflict     = conflict_q;
  assign conflict_idx = cidx_q;

endmodule
